// File: rtl/code_entry_pkg.sv
// Shared types and constants for the code-entry front end: FSM states, digit geometry,
// and the mapping from button number to digit slot.
package code_entry_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 4;

   typedef enum logic [1:0] {
      StIdle,
      StEntry,
      StSubmit
   } state_e;

   // btn[0] selects the most significant digit, so the mapping is reversed.
   function automatic logic [1:0] btn_to_digit(input logic [1:0] btn_idx);
      return 2'(NUM_DIGITS - 1) - btn_idx;
   endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer plus stability counter; the output level toggles only after the
// synchronized input has disagreed with it for CYCLES consecutive clocks.
module debounce #(
   parameter int unsigned CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_level) begin
            if (r_cnt == CNT_W'(CYCLES - 1)) begin
               r_level <= ~r_level;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign level = r_level;

endmodule

// File: rtl/code_entry.sv
// Lock keypad front end: debounces buttons and latch, captures switch nibbles into digit
// slots, and offers the completed 16-bit code over a valid/ready handshake.
module code_entry
   import code_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned TIMEOUT_CYCLES  = 1500000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  switch,
   input  logic [3:0]  btn,
   input  logic        latch,
   input  logic        code_ready,
   output logic        code_valid,
   output logic [15:0] code,
   output logic [3:0]  digit_mask,
   output logic        entry_active,
   output logic        entry_error,
   output logic        entry_timeout
);

   logic [NUM_DIGITS-1:0]              w_btn_lvl;
   logic                               w_latch_lvl;
   logic [NUM_DIGITS-1:0]              w_btn_rise;
   logic                               w_latch_fall;
   logic                               w_one_press;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_digits_cap;
   logic [NUM_DIGITS-1:0]              w_mask_cap;

   state_e                             r_state;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_digits;
   logic [NUM_DIGITS-1:0]              r_mask;
   logic [31:0]                        r_tcnt;
   logic [NUM_DIGITS-1:0]              r_btn_prev;
   logic                               r_latch_prev;
   logic                               r_code_valid;
   logic                               r_entry_error;
   logic                               r_entry_timeout;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_btn_db
      debounce #(
         .CYCLES (DEBOUNCE_CYCLES)
      ) u_btn_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn[g]),
         .level (w_btn_lvl[g])
      );
   end

   debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_latch_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (latch),
      .level (w_latch_lvl)
   );

   assign w_btn_rise   = w_btn_lvl & ~r_btn_prev;
   assign w_latch_fall = ~w_latch_lvl & r_latch_prev;
   // Exactly one rising edge: non-zero with a single bit set.
   assign w_one_press  = (w_btn_rise != '0) && ((w_btn_rise & (w_btn_rise - 4'd1)) == '0);

   always_comb begin
      w_digits_cap = r_digits;
      w_mask_cap   = r_mask;
      if (w_one_press) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_btn_rise[i]) begin
               w_digits_cap[btn_to_digit(2'(i))] = switch;
               w_mask_cap[btn_to_digit(2'(i))]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= StIdle;
         r_digits        <= '0;
         r_mask          <= '0;
         r_tcnt          <= '0;
         r_btn_prev      <= '0;
         r_latch_prev    <= 1'b0;
         r_code_valid    <= 1'b0;
         r_entry_error   <= 1'b0;
         r_entry_timeout <= 1'b0;
      end else begin
         r_btn_prev      <= w_btn_lvl;
         r_latch_prev    <= w_latch_lvl;
         r_entry_error   <= 1'b0;
         r_entry_timeout <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_one_press) begin
                  r_digits <= w_digits_cap;
                  r_mask   <= w_mask_cap;
                  r_tcnt   <= '0;
                  r_state  <= StEntry;
               end
               if (w_latch_fall) r_entry_error <= 1'b1;
            end
            StEntry: begin
               r_digits <= w_digits_cap;
               r_mask   <= w_mask_cap;
               r_tcnt   <= r_tcnt + 32'd1;
               // Submit is checked before the timeout so it wins a same-cycle collision.
               if (w_latch_fall) begin
                  if (w_mask_cap == '1) begin
                     r_code_valid <= 1'b1;
                     r_state      <= StSubmit;
                  end else begin
                     r_entry_error <= 1'b1;
                     r_digits      <= '0;
                     r_mask        <= '0;
                     r_state       <= StIdle;
                  end
               end else if (r_tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  r_entry_timeout <= 1'b1;
                  r_digits        <= '0;
                  r_mask          <= '0;
                  r_state         <= StIdle;
               end
            end
            StSubmit: begin
               if (r_code_valid && code_ready) begin
                  r_code_valid <= 1'b0;
                  r_digits     <= '0;
                  r_mask       <= '0;
                  r_state      <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign code          = r_digits;
   assign digit_mask    = r_mask;
   assign code_valid    = r_code_valid;
   assign entry_active  = (r_state != StIdle);
   assign entry_error   = r_entry_error;
   assign entry_timeout = r_entry_timeout;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry with short debounce and timeout windows.
module tb_code_entry;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  switch;
   logic [3:0]  btn;
   logic        latch;
   logic        code_ready;
   logic        code_valid;
   logic [15:0] code;
   logic [3:0]  digit_mask;
   logic        entry_active;
   logic        entry_error;
   logic        entry_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   code_entry #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_CYCLES  (200)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .switch        (switch),
      .btn           (btn),
      .latch         (latch),
      .code_ready    (code_ready),
      .code_valid    (code_valid),
      .code          (code),
      .digit_mask    (digit_mask),
      .entry_active  (entry_active),
      .entry_error   (entry_error),
      .entry_timeout (entry_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      btn        = '0;
      latch      = 1'b0;
      switch     = '0;
      code_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic press(input int idx, input logic [3:0] val);
      switch   = val;
      btn[idx] = 1'b1;
      repeat (12) tick();
      btn[idx] = 1'b0;
      repeat (12) tick();
   endtask

   task automatic release_latch();
      latch = 1'b1;
      repeat (12) tick();
      latch = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!code_valid && n < 30) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(code_valid), 32'd1);
   endtask

   task automatic wait_error(input string tag);
      int n = 0;
      while (!entry_error && n < 30) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(entry_error), 32'd1);
   endtask

   initial begin
      int  k;
      logic seen_to;

      do_reset();
      check_eq("rst_valid", 32'(code_valid), 32'd0);
      check_eq("rst_code", 32'(code), 32'd0);
      check_eq("rst_mask", 32'(digit_mask), 32'd0);
      check_eq("rst_active", 32'(entry_active), 32'd0);
      check_eq("rst_err_to", {30'd0, entry_error, entry_timeout}, 32'd0);

      // 1. Full entry and submit with a delayed ready.
      press(0, 4'h3);
      press(1, 4'h2);
      press(2, 4'h8);
      press(3, 4'h3);
      check_eq("t1_mask", 32'(digit_mask), 32'hF);
      check_eq("t1_active", 32'(entry_active), 32'd1);
      release_latch();
      wait_valid("t1_valid_rise");
      for (int i = 0; i < 10; i++) begin
         check_eq("t1_hold_valid", 32'(code_valid), 32'd1);
         check_eq("t1_hold_code", 32'(code), 32'h3283);
         tick();
      end
      code_ready = 1'b1;
      tick();
      code_ready = 1'b0;
      check_eq("t1_valid_drop", 32'(code_valid), 32'd0);
      check_eq("t1_mask_clr", 32'(digit_mask), 32'd0);
      check_eq("t1_idle", 32'(entry_active), 32'd0);

      // 2. Bounce rejection.
      do_reset();
      switch = 4'h6;
      for (int i = 0; i < 10; i++) begin
         btn[2] = ~btn[2];
         repeat (2) tick();
      end
      check_eq("t2_no_capture", 32'(digit_mask), 32'd0);
      btn[2] = 1'b1;
      repeat (12) tick();
      check_eq("t2_mask", 32'(digit_mask), 32'b0010);
      check_eq("t2_code", 32'(code), 32'h0060);

      // 3. Incomplete submit, then latch release while idle.
      do_reset();
      press(0, 4'h9);
      press(1, 4'h4);
      check_eq("t3_mask", 32'(digit_mask), 32'b1100);
      release_latch();
      wait_error("t3_err");
      check_eq("t3_mask_clr", 32'(digit_mask), 32'd0);
      check_eq("t3_idle", 32'(entry_active), 32'd0);
      tick();
      check_eq("t3_err_1cyc", 32'(entry_error), 32'd0);
      check_eq("t3_no_valid", 32'(code_valid), 32'd0);
      release_latch();
      wait_error("t3_idle_err");
      check_eq("t3_idle_stay", 32'(entry_active), 32'd0);

      // 4. Timeout 200 cycles after the capture.
      do_reset();
      switch = 4'h5;
      btn    = 4'b1000;
      k      = 0;
      while (digit_mask == 4'd0 && k < 30) begin
         tick();
         k++;
      end
      check_eq("t4_capture", 32'(digit_mask), 32'b0001);
      btn = '0;
      k   = 0;
      do begin
         tick();
         k++;
      end while (!entry_timeout && k < 300);
      check_eq("t4_to_cycle", 32'(k), 32'd200);
      check_eq("t4_inactive", 32'(entry_active), 32'd0);
      check_eq("t4_mask_clr", 32'(digit_mask), 32'd0);
      tick();
      check_eq("t4_to_1cyc", 32'(entry_timeout), 32'd0);

      // 4b. Submit lands on the same edge the timeout would fire.
      do_reset();
      switch = 4'h1;
      btn    = 4'b0001;
      k      = 0;
      while (digit_mask == 4'd0 && k < 30) begin
         tick();
         k++;
      end
      check_eq("t4b_capture", 32'(digit_mask), 32'b1000);
      seen_to = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         tick();
         if (entry_timeout) seen_to = 1'b1;
         case (n)
            1:   btn = '0;
            20:  begin switch = 4'h2; btn = 4'b0010; end
            40:  btn = '0;
            60:  begin switch = 4'h3; btn = 4'b0100; end
            80:  btn = '0;
            100: begin switch = 4'h4; btn = 4'b1000; end
            120: btn = '0;
            140: latch = 1'b1;
            193: latch = 1'b0;
            default: ;
         endcase
      end
      check_eq("t4b_valid", 32'(code_valid), 32'd1);
      check_eq("t4b_code", 32'(code), 32'h1234);
      code_ready = 1'b1;
      tick();
      code_ready = 1'b0;
      repeat (5) begin
         if (entry_timeout) seen_to = 1'b1;
         tick();
      end
      check_eq("t4b_no_timeout", 32'(seen_to), 32'd0);

      // 5. Simultaneous buttons ignored; buttons locked out in SUBMIT.
      do_reset();
      switch = 4'h7;
      btn    = 4'b0011;
      repeat (12) tick();
      check_eq("t5_dual_mask", 32'(digit_mask), 32'd0);
      check_eq("t5_dual_idle", 32'(entry_active), 32'd0);
      btn = '0;
      repeat (12) tick();
      press(0, 4'hA);
      press(1, 4'hB);
      press(2, 4'hC);
      press(3, 4'hD);
      release_latch();
      wait_valid("t5_valid");
      press(3, 4'hF);
      check_eq("t5_lock_code", 32'(code), 32'hABCD);
      check_eq("t5_lock_valid", 32'(code_valid), 32'd1);
      code_ready = 1'b1;
      tick();
      code_ready = 1'b0;
      check_eq("t5_ack", 32'(code_valid), 32'd0);

      // 6. Asynchronous reset while the code is offered.
      do_reset();
      press(0, 4'h1);
      press(1, 4'h1);
      press(2, 4'h1);
      press(3, 4'h1);
      release_latch();
      wait_valid("t6_valid");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_eq("t6_async_valid", 32'(code_valid), 32'd0);
      check_eq("t6_async_code", 32'(code), 32'd0);
      check_eq("t6_async_mask", 32'(digit_mask), 32'd0);
      #10;
      rst = 1'b0;
      tick();
      check_eq("t6_idle", 32'(entry_active), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
